hovalaag_run_ctrl: RTL and testbench
====================================

// Module: hovalaag_run_ctrl
// PURPOSE
//  Parametrised CPU run controller for the Hovalaag harness. Generates the CPU clock (cpu_clk)
//  and one-shot IO strobes from the board clock, in single-step or free-run mode with a
//  programmable divider. Adds PC breakpoints, per-channel pause-on-output and a cycle counter.
//  Sits between the board buttons/switches and the CPU, Input and Fifo blocks.
// PARAMETERS
//  DIV_WIDTH  24  width of run_div / half-period down-counter
//  ADDR_WIDTH 8   PC width
//  NUM_BP     2   number of breakpoint comparators
//  NUM_OUT    2   number of CPU output channels (OUT_SEL_W = max(1,$clog2(NUM_OUT)))
//  CNT_WIDTH  32  executed-cycle counter width
// PORTS
//  clk            in   1                 board clock; every register is on posedge
//  reset_n        in   1                 asynchronous, active-low reset
//  run_mode       in   1                 1 = free run, 0 = single step
//  run_div        in   DIV_WIDTH         cpu_clk half-period in clk cycles, minus 1
//  step_btn       in   1                 step request, synchronised level
//  cont_btn       in   1                 continue request, synchronised level
//  pc             in   ADDR_WIDTH        CPU next-instruction address
//  bp_addr        in   NUM_BP*ADDR_WIDTH packed breakpoint addresses, [0] in the LSBs
//  bp_en          in   NUM_BP            per-breakpoint enable
//  out_valid      in   1                 CPU output write strobe
//  out_select     in   OUT_SEL_W         channel of the current write
//  out_pause_mask in   NUM_OUT           1 = pause on a write to that channel
//  cnt_clr        in   1                 synchronous clear of cycle_count
//  cpu_clk        out  1                 registered CPU clock
//  cpu_rise       out  1                 1-clk pulse in the cycle cpu_clk goes 0->1 (IN advance)
//  cpu_rise_d     out  1                 cpu_rise delayed 1 clk (OUT capture, bp check)
//  paused         out  1                 in PAUSED state
//  pause_cause    out  3                 {manual-reserved=0, out, bp}; sticky until continue
//  bp_hit         out  NUM_BP            which comparators matched; sticky until continue
//  cycle_count    out  CNT_WIDTH         rising edges issued; saturates at all-ones
// BEHAVIOUR
//  Reset: all outputs 0, state STOPPED, divider counter 0, button edge registers 0.
//  Button edges: rising edge = level 1 now, 0 in the previous clk. Inputs arrive synchronised.
//  States: STOPPED, RUN, PAUSED.
//   STOPPED: an edge on step_btn sets cpu_clk=1 for exactly 1 clk, then 0. cpu_rise
//            coincides with that high clk. run_mode=1 -> RUN, loading counter=run_div, cpu_clk=0.
//   RUN: counter decrements each clk. At 0 it toggles cpu_clk and reloads run_div (new
//        run_div takes effect at reload). run_div=0 -> cpu_clk period is 2 clk.
//        run_mode=0 -> STOPPED next clk, cpu_clk forced 0.
//   PAUSED: cpu_clk held 0 and no cpu_rise. An edge on step_btn performs one single-clk step
//           and stays PAUSED. An edge on cont_btn clears pause_cause/bp_hit and goes to RUN
//           (run_mode=1) or STOPPED (run_mode=0).
//  Pause triggers, from STOPPED or RUN:
//   - out: out_valid && out_pause_mask[out_select]. out_select >= NUM_OUT is ignored.
//   - bp: in the cpu_rise_d cycle, any bp_en[i] && pc==bp_addr[i].
//  Next clk: PAUSED, cpu_clk forced 0, cause bits set.
//  A cpu_rise already issued still yields its cpu_rise_d.
//  Priority: reset > trigger > cont edge > step edge. A trigger in the same clk as a cont edge
//   leaves the block PAUSED, with new cause bits ORed into the old ones.
//  No re-trigger after cont at a breakpoint PC: the bp is checked only on cpu_rise_d.
//  cycle_count: +1 on each cpu_rise, saturating; cnt_clr wins over an increment.
//  Async reset mid-RUN: cpu_clk drops to 0 immediately; no pulse is emitted.
// STRUCTURE
//  Shared package/include hovalaag_run_pkg: state encodings (STOPPED=0, RUN=1, PAUSED=2) and
//   the bit indices PC_BP=0, PC_OUT=1 for pause_cause.
//  Sub-module hovalaag_bp_match: NUM_BP parallel comparators -> hit vector. Combinational,
//   instantiated once. FSM, divider and counter live in this module.
// TESTING
//  Step: reset, run_mode=0, step_btn 0->1 held 5 clk -> exactly one cpu_clk high clk and one
//   cpu_rise; cycle_count=1.
//  Run: run_div=3, run_mode=1 -> cpu_clk period 8 clk, cpu_rise every 8 clk, cpu_rise_d 1 clk
//   later. Change run_div to 0 -> period 2 after the next reload.
//  Breakpoint: bp_addr[0]=8'h05, bp_en=01; pc reaches 05 -> paused=1 the clk after
//   cpu_rise_d, pause_cause=3'b001, bp_hit=01. cont -> resumes and does not re-trigger at 05.
//  Out pause: mask=2'b01; out_valid with select=1 -> no pause; with select=0 -> paused,
//   cause=3'b010. A simultaneous cont edge -> remains paused.
//  Paused step: while PAUSED, step_btn edge -> one cpu_rise; paused stays 1.
//  Corners: cycle_count preset near all-ones saturates; cnt_clr with cpu_rise -> 0;
//   reset_n low mid-run -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/hovalaag_run_pkg.sv
// Shared definitions for the Hovalaag CPU run controller.
//   run_state_e : controller states (STOPPED=0, RUN=1, PAUSED=2)
//   PC_*        : bit positions inside pause_cause
package hovalaag_run_pkg;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2
    } run_state_e;

    localparam int PC_BP     = 0;   // paused by a breakpoint match
    localparam int PC_OUT    = 1;   // paused by a write to a masked output channel
    localparam int PC_MANUAL = 2;   // reserved, always 0
    localparam int CAUSE_W   = 3;

endpackage

// File: rtl/hovalaag_bp_match.sv
// Breakpoint comparators: NUM_BP parallel address compares against the CPU PC.
// Ports:
//   pc      in  ADDR_WIDTH         CPU next-instruction address
//   bp_addr in  NUM_BP*ADDR_WIDTH  packed breakpoint addresses, entry 0 in the LSBs
//   bp_en   in  NUM_BP             per-comparator enable
//   hit     out NUM_BP             enabled comparators whose address equals pc
module hovalaag_bp_match
    import hovalaag_run_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_BP     = 2
) (
    input  logic [ADDR_WIDTH-1:0]        pc,
    input  logic [NUM_BP*ADDR_WIDTH-1:0] bp_addr,
    input  logic [NUM_BP-1:0]            bp_en,
    output logic [NUM_BP-1:0]            hit
);

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_BP; i++) begin
            hit[i] = bp_en[i] && (bp_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == pc);
        end
    end

endmodule

// File: rtl/hovalaag_run_ctrl.sv
// CPU run controller for the Hovalaag harness. Derives the CPU clock and its
// IO strobes from the board clock in single-step or free-run mode, with PC
// breakpoints, pause-on-output and an executed-cycle counter.
// Ports:
//   clk, reset_n     board clock, asynchronous active-low reset
//   run_mode         1 = free run, 0 = single step
//   run_div          cpu_clk half-period in clk cycles, minus 1
//   step_btn         step request (synchronised level, acts on rising edge)
//   cont_btn         continue request (synchronised level, acts on rising edge)
//   pc               CPU next-instruction address
//   bp_addr, bp_en   packed breakpoint addresses and enables
//   out_valid        CPU output write strobe, out_select = its channel
//   out_pause_mask   per-channel pause-on-write enable
//   cnt_clr          synchronous clear of cycle_count
//   cpu_clk          registered CPU clock
//   cpu_rise         1-clk pulse in the first high clk of cpu_clk
//   cpu_rise_d       cpu_rise delayed one clk
//   paused           controller is in PAUSED
//   pause_cause      {reserved, out, bp}, sticky until continue
//   bp_hit           matching comparators, sticky until continue
//   cycle_count      number of cpu_rise pulses, saturating
module hovalaag_run_ctrl
    import hovalaag_run_pkg::*;
#(
    parameter  int DIV_WIDTH  = 24,
    parameter  int ADDR_WIDTH = 8,
    parameter  int NUM_BP     = 2,
    parameter  int NUM_OUT    = 2,
    parameter  int CNT_WIDTH  = 32,
    localparam int OUT_SEL_W  = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         run_mode,
    input  logic [DIV_WIDTH-1:0]         run_div,
    input  logic                         step_btn,
    input  logic                         cont_btn,
    input  logic [ADDR_WIDTH-1:0]        pc,
    input  logic [NUM_BP*ADDR_WIDTH-1:0] bp_addr,
    input  logic [NUM_BP-1:0]            bp_en,
    input  logic                         out_valid,
    input  logic [OUT_SEL_W-1:0]         out_select,
    input  logic [NUM_OUT-1:0]           out_pause_mask,
    input  logic                         cnt_clr,
    output logic                         cpu_clk,
    output logic                         cpu_rise,
    output logic                         cpu_rise_d,
    output logic                         paused,
    output logic [CAUSE_W-1:0]           pause_cause,
    output logic [NUM_BP-1:0]            bp_hit,
    output logic [CNT_WIDTH-1:0]         cycle_count
);

    run_state_e           r_state, w_state_nxt;
    logic [DIV_WIDTH-1:0] r_div_cnt, w_div_cnt_nxt;
    logic                 r_cpu_clk, w_cpu_clk_nxt;
    logic                 r_cpu_rise, r_cpu_rise_d;
    logic [CAUSE_W-1:0]   r_pause_cause, w_pause_cause_nxt;
    logic [NUM_BP-1:0]    r_bp_hit, w_bp_hit_nxt;
    logic [CNT_WIDTH-1:0] r_cycle_count;
    logic                 r_step_q, r_cont_q;

    logic                 w_step_edge, w_cont_edge;
    logic                 w_out_trig, w_bp_trig;
    logic [NUM_BP-1:0]    w_bp_match;

    assign w_step_edge = step_btn & ~r_step_q;
    assign w_cont_edge = cont_btn & ~r_cont_q;

    hovalaag_bp_match #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_BP     (NUM_BP)
    ) u_bp_match (
        .pc      (pc),
        .bp_addr (bp_addr),
        .bp_en   (bp_en),
        .hit     (w_bp_match)
    );

    // The PC is only meaningful right after the CPU has taken a rising edge,
    // so breakpoints are sampled in the cpu_rise_d clk only. That is also what
    // lets a continue at a breakpoint address run on without re-triggering.
    assign w_bp_trig  = r_cpu_rise_d && (|w_bp_match);
    // Writes to channels that do not exist never pause.
    assign w_out_trig = out_valid && (int'(out_select) < NUM_OUT) && out_pause_mask[out_select];

    // Trigger beats continue beats step; a trigger arriving while already
    // paused just accumulates cause bits.
    always_comb begin
        w_state_nxt       = r_state;
        w_div_cnt_nxt     = r_div_cnt;
        w_cpu_clk_nxt     = 1'b0;
        w_pause_cause_nxt = r_pause_cause;
        w_bp_hit_nxt      = r_bp_hit;

        if (w_out_trig || w_bp_trig) begin
            w_state_nxt               = ST_PAUSED;
            w_pause_cause_nxt[PC_OUT] = r_pause_cause[PC_OUT] | w_out_trig;
            w_pause_cause_nxt[PC_BP]  = r_pause_cause[PC_BP]  | w_bp_trig;
            if (w_bp_trig) begin
                w_bp_hit_nxt = r_bp_hit | w_bp_match;
            end
        end else begin
            unique case (r_state)
                ST_STOPPED: begin
                    if (run_mode) begin
                        w_state_nxt   = ST_RUN;
                        w_div_cnt_nxt = run_div;
                    end else begin
                        w_cpu_clk_nxt = w_step_edge;
                    end
                end
                ST_RUN: begin
                    if (!run_mode) begin
                        w_state_nxt = ST_STOPPED;
                    end else if (r_div_cnt == '0) begin
                        // run_div is sampled only here, so a new divider
                        // takes effect at the next half-period boundary.
                        w_div_cnt_nxt = run_div;
                        w_cpu_clk_nxt = ~r_cpu_clk;
                    end else begin
                        w_div_cnt_nxt = r_div_cnt - DIV_WIDTH'(1);
                        w_cpu_clk_nxt = r_cpu_clk;
                    end
                end
                ST_PAUSED: begin
                    if (w_cont_edge) begin
                        w_pause_cause_nxt = '0;
                        w_bp_hit_nxt      = '0;
                        if (run_mode) begin
                            w_state_nxt   = ST_RUN;
                            w_div_cnt_nxt = run_div;
                        end else begin
                            w_state_nxt = ST_STOPPED;
                        end
                    end else begin
                        w_cpu_clk_nxt = w_step_edge;
                    end
                end
                default: begin
                    w_state_nxt = ST_STOPPED;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours, whatever the order of
    // statements inside the block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_STOPPED;
            r_div_cnt     <= '0;
            r_cpu_clk     <= 1'b0;
            r_cpu_rise    <= 1'b0;
            r_cpu_rise_d  <= 1'b0;
            r_pause_cause <= '0;
            r_bp_hit      <= '0;
            r_cycle_count <= '0;
            r_step_q      <= 1'b0;
            r_cont_q      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_div_cnt     <= w_div_cnt_nxt;
            r_cpu_clk     <= w_cpu_clk_nxt;
            r_cpu_rise    <= w_cpu_clk_nxt & ~r_cpu_clk;
            r_cpu_rise_d  <= r_cpu_rise;
            r_pause_cause <= w_pause_cause_nxt;
            r_bp_hit      <= w_bp_hit_nxt;
            r_step_q      <= step_btn;
            r_cont_q      <= cont_btn;
            if (cnt_clr) begin
                r_cycle_count <= '0;
            end else if (r_cpu_rise && (r_cycle_count != '1)) begin
                r_cycle_count <= r_cycle_count + CNT_WIDTH'(1);
            end
        end
    end

    assign cpu_clk     = r_cpu_clk;
    assign cpu_rise    = r_cpu_rise;
    assign cpu_rise_d  = r_cpu_rise_d;
    assign paused      = (r_state == ST_PAUSED);
    assign pause_cause = r_pause_cause;
    assign bp_hit      = r_bp_hit;
    assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_hovalaag_run_ctrl.sv
// Self-checking bench for hovalaag_run_ctrl: directed scenarios followed by
// randomized stimulus, every clk compared against a behavioural model.
module tb_hovalaag_run_ctrl;

    localparam int DIV_W  = 8;
    localparam int ADDR_W = 8;
    localparam int NBP    = 2;
    localparam int NOUT   = 3;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 6;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  run_mode = 1'b0;
    logic [DIV_W-1:0]      run_div = '0;
    logic                  step_btn = 1'b0;
    logic                  cont_btn = 1'b0;
    logic [ADDR_W-1:0]     pc = '0;
    logic [NBP*ADDR_W-1:0] bp_addr = '0;
    logic [NBP-1:0]        bp_en = '0;
    logic                  out_valid = 1'b0;
    logic [SEL_W-1:0]      out_select = '0;
    logic [NOUT-1:0]       out_pause_mask = '0;
    logic                  cnt_clr = 1'b0;
    logic                  cpu_clk, cpu_rise, cpu_rise_d, paused;
    logic [2:0]            pause_cause;
    logic [NBP-1:0]        bp_hit;
    logic [CNT_W-1:0]      cycle_count;

    hovalaag_run_ctrl #(
        .DIV_WIDTH (DIV_W), .ADDR_WIDTH (ADDR_W), .NUM_BP (NBP),
        .NUM_OUT (NOUT), .CNT_WIDTH (CNT_W)
    ) dut (
        .clk (clk), .reset_n (reset_n), .run_mode (run_mode), .run_div (run_div),
        .step_btn (step_btn), .cont_btn (cont_btn), .pc (pc), .bp_addr (bp_addr),
        .bp_en (bp_en), .out_valid (out_valid), .out_select (out_select),
        .out_pause_mask (out_pause_mask), .cnt_clr (cnt_clr), .cpu_clk (cpu_clk),
        .cpu_rise (cpu_rise), .cpu_rise_d (cpu_rise_d), .paused (paused),
        .pause_cause (pause_cause), .bp_hit (bp_hit), .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit pc_follow = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Mode is kept as two flags (running / halted-for-pause); the divider is
    // tracked as "clks left before the next toggle".
    bit          m_run, m_halt;
    int          m_left;
    bit          m_clk, m_rise, m_rise_d;
    bit [2:0]    m_cause;
    bit [NBP-1:0] m_hit;
    int unsigned m_count;
    bit          m_step_prev, m_cont_prev;

    task automatic model_reset();
        m_run = 0; m_halt = 0; m_left = 0;
        m_clk = 0; m_rise = 0; m_rise_d = 0;
        m_cause = '0; m_hit = '0; m_count = 0;
        m_step_prev = 0; m_cont_prev = 0;
    endtask

    // Applies the current inputs as one posedge of clk.
    task automatic model_advance();
        bit           step_e, cont_e, out_t, new_clk;
        bit [NBP-1:0] bpv;
        step_e = step_btn && !m_step_prev;
        cont_e = cont_btn && !m_cont_prev;
        out_t  = out_valid && (int'(out_select) < NOUT) && out_pause_mask[out_select];
        bpv    = '0;
        if (m_rise_d)
            for (int i = 0; i < NBP; i++)
                if (bp_en[i] && pc == bp_addr[i*ADDR_W +: ADDR_W]) bpv[i] = 1'b1;

        if (cnt_clr) m_count = 0;
        else if (m_rise && m_count < CNT_MAX) m_count++;

        new_clk = 1'b0;
        if (out_t || bpv != 0) begin
            m_halt = 1; m_run = 0;
            if (out_t) m_cause[1] = 1'b1;
            if (bpv != 0) m_cause[0] = 1'b1;
            m_hit |= bpv;
        end else if (m_halt) begin
            if (cont_e) begin
                m_halt = 0; m_cause = '0; m_hit = '0;
                m_run = run_mode; m_left = int'(run_div) + 1;
            end else begin
                new_clk = step_e;
            end
        end else if (m_run) begin
            if (!run_mode) m_run = 0;
            else begin
                m_left--;
                if (m_left == 0) begin
                    new_clk = !m_clk;
                    m_left = int'(run_div) + 1;
                end else new_clk = m_clk;
            end
        end else begin
            if (run_mode) begin m_run = 1; m_left = int'(run_div) + 1; end
            else new_clk = step_e;
        end
        m_rise_d = m_rise;
        m_rise   = new_clk && !m_clk;
        m_clk    = new_clk;
        m_step_prev = step_btn;
        m_cont_prev = cont_btn;
    endtask

    task automatic compare_all();
        check("cpu_clk",     64'(cpu_clk),     64'(m_clk));
        check("cpu_rise",    64'(cpu_rise),    64'(m_rise));
        check("cpu_rise_d",  64'(cpu_rise_d),  64'(m_rise_d));
        check("paused",      64'(paused),      64'(m_halt));
        check("pause_cause", 64'(pause_cause), 64'(m_cause));
        check("bp_hit",      64'(bp_hit),      64'(m_hit));
        check("cycle_count", 64'(cycle_count), 64'(m_count));
    endtask

    // Called at a negedge with inputs already set for the coming posedge.
    task automatic tick();
        model_advance();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        compare_all();
        if (pc_follow && cpu_rise) pc = pc + 1'b1;
    endtask

    int n, hi, rises, t0;

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_cpu_clk", 64'(cpu_clk), 64'd0);
        check("reset_paused",  64'(paused), 64'd0);
        check("reset_count",   64'(cycle_count), 64'd0);
        reset_n = 1'b1;

        // Single step: level held 5 clk yields exactly one pulse.
        step_btn = 1'b1; hi = 0; rises = 0;
        repeat (5) begin tick(); hi += int'(cpu_clk); rises += int'(cpu_rise); end
        step_btn = 1'b0; tick();
        check("step_high_clks", 64'(hi), 64'd1);
        check("step_rises", 64'(rises), 64'd1);
        check("step_count", 64'(cycle_count), 64'd1);

        // Free run, run_div=3 -> period 8.
        run_div = 8'd3; run_mode = 1'b1;
        n = 0; while (!cpu_rise && n < 40) begin tick(); n++; end
        check("run_first_rise", 64'(cpu_rise), 64'd1);
        t0 = cyc; tick();
        check("run_rise_d", 64'(cpu_rise_d), 64'd1);
        n = 0; while (!cpu_rise && n < 40) begin tick(); n++; end
        check("run_period8", 64'(cyc - t0), 64'd8);

        run_div = 8'd0;
        repeat (12) tick();
        n = 0; while (!cpu_rise && n < 40) begin tick(); n++; end
        t0 = cyc; tick();
        n = 0; while (!cpu_rise && n < 40) begin tick(); n++; end
        check("run_period2", 64'(cyc - t0), 64'd2);

        // Breakpoint at 05 with a PC that advances after each CPU edge.
        bp_addr = {8'hA0, 8'h05}; bp_en = 2'b01; pc = '0; pc_follow = 1'b1;
        n = 0; while (!paused && n < 100) begin tick(); n++; end
        check("bp_paused", 64'(paused), 64'd1);
        check("bp_cause", 64'(pause_cause), 64'b001);
        check("bp_hit", 64'(bp_hit), 64'b01);
        check("bp_pc", 64'(pc), 64'h05);
        repeat (3) tick();
        check("bp_held_clk", 64'(cpu_clk), 64'd0);
        cont_btn = 1'b1; tick(); cont_btn = 1'b0;
        check("bp_cont_paused", 64'(paused), 64'd0);
        check("bp_cont_cause", 64'(pause_cause), 64'd0);
        hi = 0;
        repeat (20) begin tick(); hi += int'(paused); end
        check("bp_no_retrigger", 64'(hi), 64'd0);
        pc_follow = 1'b0; bp_en = '0;

        // Out pause: nonexistent channel, unmasked channel, masked channel.
        out_pause_mask = 3'b111; out_select = 2'd3; out_valid = 1'b1; tick();
        out_valid = 1'b0; tick();
        check("out_sel_oob", 64'(paused), 64'd0);
        out_pause_mask = 3'b001; out_select = 2'd1; out_valid = 1'b1; tick();
        out_valid = 1'b0; tick();
        check("out_unmasked", 64'(paused), 64'd0);
        out_select = 2'd0; out_valid = 1'b1; tick();
        out_valid = 1'b0;
        check("out_paused", 64'(paused), 64'd1);
        check("out_cause", 64'(pause_cause), 64'b010);
        cont_btn = 1'b1; out_valid = 1'b1; tick();
        cont_btn = 1'b0; out_valid = 1'b0;
        check("out_cont_collide", 64'(paused), 64'd1);
        tick();

        // Step while paused.
        step_btn = 1'b1; tick();
        check("pstep_rise", 64'(cpu_rise), 64'd1);
        check("pstep_paused", 64'(paused), 64'd1);
        step_btn = 1'b0; tick(); tick();
        check("pstep_still", 64'(paused), 64'd1);
        cont_btn = 1'b1; tick(); cont_btn = 1'b0; tick();

        // Saturation, then clear colliding with a rise.
        repeat (150) tick();
        check("count_sat", 64'(cycle_count), 64'(CNT_MAX));
        n = 0; while (!cpu_rise && n < 40) begin tick(); n++; end
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        check("count_clr_wins", 64'(cycle_count), 64'd0);

        // Asynchronous reset while cpu_clk is high.
        n = 0; while (!cpu_clk && n < 40) begin tick(); n++; end
        #2 reset_n = 1'b0;
        #1;
        check("areset_cpu_clk", 64'(cpu_clk), 64'd0);
        check("areset_rise", 64'(cpu_rise), 64'd0);
        check("areset_count", 64'(cycle_count), 64'd0);
        model_reset();
        @(negedge clk); reset_n = 1'b1;

        // Randomized traffic.
        bp_addr = {8'd3, 8'd5};
        for (int k = 0; k < 3000; k++) begin
            run_mode  = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 7) == 0) run_div = 8'($urandom_range(0, 3));
            step_btn  = ($urandom_range(0, 5) == 0);
            cont_btn  = ($urandom_range(0, 9) == 0);
            pc        = 8'($urandom_range(0, 7));
            out_valid = ($urandom_range(0, 19) == 0);
            out_select = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) out_pause_mask = 3'($urandom);
            if ($urandom_range(0, 31) == 0) bp_en = 2'($urandom);
            cnt_clr   = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
